// File: rtl/calib_pkg.sv
// Shared types and constants for the threshold calibrator.
// Holds the FSM state encoding and the saturation guard-bit constants.
package calib_pkg;

   typedef enum logic [1:0] {
      CAL_IDLE,
      CAL_ACQUIRE,
      CAL_COMPUTE,
      CAL_RUN
   } calib_state_t;

   // Extra bits above the channel width for the threshold arithmetic.
   // Two guard bits hold center +/- a full-range hysteresis without overflow.
   localparam int SAT_GUARD = 2;

   // Length of the tracker reset pulse, in clock cycles.
   localparam int TR_PULSE = 2;

endpackage

// File: rtl/minmax_accumulator.sv
// Signed running min/max of one sample stream plus a sample counter.
// Ports: clk, rst_n, clear, sample_en, sample -> min_val, max_val, count.
module minmax_accumulator #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     sample_en,
   input  logic signed [DATA_W-1:0] sample,
   output logic signed [DATA_W-1:0] min_val,
   output logic signed [DATA_W-1:0] max_val,
   output logic        [CNT_W-1:0]  count
);

   // Empty state: min at the top of the range, max at its negation.
   localparam logic signed [DATA_W-1:0] POS_MAX =
      {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] NEG_MAX = -POS_MAX;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_val <= POS_MAX;
         max_val <= NEG_MAX;
         count   <= '0;
      end else if (clear) begin
         min_val <= POS_MAX;
         max_val <= NEG_MAX;
         count   <= '0;
      end else if (sample_en) begin
         if (sample < min_val)
            min_val <= sample;
         if (sample > max_val)
            max_val <= sample;
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/threshold_calibrator.sv
// Measures channel-A min/max over a window and derives tracker thresholds.
// Ports: SYS clock/reset, FC control, S_AXIS in, M_AXIS out, TH_*, TR, ST_*.
module threshold_calibrator
   import calib_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int WINDOW_WIDTH     = 24
) (
   input  logic                                SYS_aclk,
   input  logic                                SYS_aresetn,
   input  logic                                FC_start,
   input  logic [WINDOW_WIDTH-1:0]             FC_window,
   input  logic [2:0]                          FC_hyst_shift,
   input  logic                                S_AXIS_tvalid,
   input  logic [AXIS_TDATA_WIDTH-1:0]         S_AXIS_tdata,
   output logic                                S_AXIS_tready,
   output logic                                M_AXIS_tvalid,
   output logic [AXIS_TDATA_WIDTH-1:0]         M_AXIS_tdata,
   input  logic                                M_AXIS_tready,
   output logic signed [AXIS_TDATA_WIDTH/2-1:0] TH_lower,
   output logic signed [AXIS_TDATA_WIDTH/2-1:0] TH_upper,
   output logic                                TR_aresetn,
   output logic                                ST_busy,
   output logic                                ST_error
);

   localparam int CH_W = AXIS_TDATA_WIDTH / 2;
   localparam int CW   = CH_W + SAT_GUARD;

   localparam logic signed [CW-1:0] SAT_MAX =
      {{(SAT_GUARD+1){1'b0}}, {(CH_W-1){1'b1}}};
   localparam logic signed [CW-1:0] SAT_MIN =
      {{(SAT_GUARD+1){1'b1}}, {(CH_W-1){1'b0}}};
   localparam logic [1:0] PULSE_LAST = 2'(TR_PULSE - 1);

   calib_state_t            state;
   logic [WINDOW_WIDTH-1:0] win_q;
   logic [2:0]              shift_q;
   logic                    thr_valid;
   logic                    settle;
   logic [1:0]              pulse_cnt;

   logic signed [CH_W-1:0]  ch_a;
   logic signed [CH_W-1:0]  acc_min;
   logic signed [CH_W-1:0]  acc_max;
   logic [WINDOW_WIDTH-1:0] acc_cnt;
   logic                    sample_en;
   logic                    last_sample;

   logic signed [CW-1:0]    mn_x;
   logic signed [CW-1:0]    mx_x;
   logic signed [CW-1:0]    sum;
   logic signed [CW-1:0]    center;
   logic signed [CW-1:0]    span;
   logic signed [CW-1:0]    hyst;
   logic signed [CW-1:0]    lower;
   logic signed [CW-1:0]    upper;

   logic                    unused_tready;

   assign unused_tready = M_AXIS_tready;
   assign S_AXIS_tready = 1'b1;

   assign ch_a = S_AXIS_tdata[CH_W-1:0];

   // A start pulse wins over any sample in the same cycle.
   assign sample_en = (state == CAL_ACQUIRE)
                    && S_AXIS_tvalid && !FC_start;
   assign last_sample = sample_en
                      && (acc_cnt == win_q - 1'b1);

   minmax_accumulator #(
      .DATA_W (CH_W),
      .CNT_W  (WINDOW_WIDTH)
   ) u_acc (
      .clk       (SYS_aclk),
      .rst_n     (SYS_aresetn),
      .clear     (FC_start),
      .sample_en (sample_en),
      .sample    (ch_a),
      .min_val   (acc_min),
      .max_val   (acc_max),
      .count     (acc_cnt)
   );

   assign mn_x   = {{SAT_GUARD{acc_min[CH_W-1]}}, acc_min};
   assign mx_x   = {{SAT_GUARD{acc_max[CH_W-1]}}, acc_max};
   assign sum    = mx_x + mn_x;
   assign center = sum >>> 1;
   assign span   = mx_x - mn_x;
   // span is never negative, so the arithmetic shift acts as a logical one.
   assign hyst   = span >>> shift_q;
   assign lower  = center - hyst;
   assign upper  = center + hyst;

   function automatic logic signed [CH_W-1:0] sat(
      input logic signed [CW-1:0] v
   );
      if (v > SAT_MAX)
         return SAT_MAX[CH_W-1:0];
      if (v < SAT_MIN)
         return SAT_MIN[CH_W-1:0];
      return v[CH_W-1:0];
   endfunction

   // COMPUTE has two phases: the evaluation cycle, then (settle=1)
   // the tracker reset pulse before handing over to RUN.
   always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
      if (!SYS_aresetn) begin
         state      <= CAL_IDLE;
         TH_lower   <= '0;
         TH_upper   <= '0;
         TR_aresetn <= 1'b0;
         ST_busy    <= 1'b0;
         ST_error   <= 1'b0;
         win_q      <= '0;
         shift_q    <= '0;
         thr_valid  <= 1'b0;
         settle     <= 1'b0;
         pulse_cnt  <= '0;
      end else begin
         TR_aresetn <= 1'b1;
         if (FC_start) begin
            state   <= CAL_ACQUIRE;
            ST_busy <= 1'b1;
            settle  <= 1'b0;
            shift_q <= FC_hyst_shift;
            win_q   <= (FC_window == '0)
                     ? WINDOW_WIDTH'(1) : FC_window;
         end else begin
            unique case (state)
               CAL_ACQUIRE: begin
                  if (last_sample)
                     state <= CAL_COMPUTE;
               end
               CAL_COMPUTE: begin
                  if (settle) begin
                     pulse_cnt <= pulse_cnt + 1'b1;
                     if (pulse_cnt == PULSE_LAST) begin
                        state   <= CAL_RUN;
                        ST_busy <= 1'b0;
                        settle  <= 1'b0;
                     end else begin
                        TR_aresetn <= 1'b0;
                     end
                  end else if (hyst == '0) begin
                     ST_error <= 1'b1;
                     ST_busy  <= 1'b0;
                     state    <= thr_valid ? CAL_RUN : CAL_IDLE;
                  end else begin
                     TH_lower   <= sat(lower);
                     TH_upper   <= sat(upper);
                     ST_error   <= 1'b0;
                     thr_valid  <= 1'b1;
                     TR_aresetn <= 1'b0;
                     settle     <= 1'b1;
                     pulse_cnt  <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
      if (!SYS_aresetn) begin
         M_AXIS_tvalid <= 1'b0;
         M_AXIS_tdata  <= '0;
      end else begin
         M_AXIS_tvalid <= S_AXIS_tvalid && (state == CAL_RUN);
         M_AXIS_tdata  <= S_AXIS_tdata;
      end
   end

endmodule

// File: doc/threshold_calibrator.md
THRESHOLD_CALIBRATOR -- requirements
Module: threshold_calibrator

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, input sample width; channel A = low half, channel B = high half.
REQ-002 SHALL have parameter WINDOW_WIDTH, default 24, width of the calibration-window sample counter.
REQ-003 SHALL have port SYS_aclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port SYS_aresetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port FC_start  input  1  single-cycle pulse requesting a calibration.
REQ-006 SHALL have port FC_window  input  WINDOW_WIDTH  number of valid samples per calibration; 0 is treated as 1.
REQ-007 SHALL have port FC_hyst_shift  input  3  hysteresis = span >> FC_hyst_shift.
REQ-008 SHALL have port S_AXIS_tvalid  input  1  sample valid.
REQ-009 SHALL have port S_AXIS_tdata  input  AXIS_TDATA_WIDTH  packed signed samples {B, A}.
REQ-010 SHALL have port S_AXIS_tready  output  1  constant 1.
REQ-011 SHALL have port M_AXIS_tvalid  output  1  forwarded sample valid to the tracker.
REQ-012 SHALL have port M_AXIS_tdata  output  AXIS_TDATA_WIDTH  forwarded sample.
REQ-013 SHALL have port M_AXIS_tready  input  1  ignored; the downstream block always accepts.
REQ-014 SHALL have port TH_lower  output  AXIS_TDATA_WIDTH/2  signed lower threshold for the tracker.
REQ-015 SHALL have port TH_upper  output  AXIS_TDATA_WIDTH/2  signed upper threshold for the tracker.
REQ-016 SHALL have port TR_aresetn  output  1  active-low reset to the tracker, registered.
REQ-017 SHALL have port ST_busy  output  1  high in ACQUIRE or COMPUTE.
REQ-018 SHALL have port ST_error  output  1  sticky flag: last calibration was rejected.

Function
REQ-019 SHALL implement FSM states IDLE, ACQUIRE, COMPUTE, RUN; reset state is IDLE.
REQ-020 SHALL move IDLE/RUN -> ACQUIRE on FC_start: clear the counter, load min = +max signed and max = -max signed, and latch FC_window and FC_hyst_shift.
REQ-021 SHALL update in ACQUIRE, on each cycle with S_AXIS_tvalid=1, the signed min/max of channel A and increment the counter; cycles without tvalid are ignored.
REQ-022 SHALL move ACQUIRE -> COMPUTE in the cycle after the sample that makes the count equal the latched window.
REQ-023 SHALL restart acquisition from empty when FC_start arrives in ACQUIRE or COMPUTE; any partial result is discarded.
REQ-024 SHALL compute in COMPUTE (1 cycle, width+1 signed arithmetic, no overflow): center = (max+min)>>>1; span = max-min; hyst = span>>shift; lower = center-hyst; upper = center+hyst.
REQ-025 SHALL reject the calibration when hyst == 0: set ST_error, keep TH_* unchanged, and return to RUN if thresholds were ever valid, else IDLE.
REQ-026 SHALL register lower/upper into TH_lower/TH_upper on acceptance, clear ST_error, drive TR_aresetn low for exactly 2 cycles, then enter RUN.
REQ-027 SHALL forward samples in RUN with 1-cycle latency: M_AXIS_tdata = previous S_AXIS_tdata, M_AXIS_tvalid = previous tvalid AND RUN; tvalid is 0 in all other states.
REQ-028 SHALL saturate the results of REQ-024 to the signed AXIS_TDATA_WIDTH/2 range before registering.

Reset
REQ-029 SHALL drive on SYS_aresetn low, immediately: state IDLE, TH_lower=0, TH_upper=0, TR_aresetn=0, ST_busy=0, ST_error=0, M_AXIS_tvalid=0, M_AXIS_tdata=0, counter=0.
REQ-030 SHALL release TR_aresetn one cycle after SYS_aresetn deasserts; a reset mid-ACQUIRE discards all statistics.

Structure
REQ-031 SHALL place the FSM state encodings and the saturate width constants in a shared package calib_pkg.
REQ-032 SHALL contain one sub-module, minmax_accumulator (signed min/max plus counter); all other logic stays in threshold_calibrator.

Verification
REQ-033 SHALL cover: window=4, shift=2, A = 100, -300, 500, 20 -> TH_lower=-100, TH_upper=300, TR_aresetn low for 2 cycles, then RUN.
REQ-034 SHALL cover: window=3, constant A=50 -> span 0, ST_error=1, TH_* stay 0, state IDLE.
REQ-035 SHALL cover: window=4 with tvalid gaps (samples on every other cycle) -> same result as REQ-033, COMPUTE entered after the 4th valid sample.
REQ-036 SHALL cover: FC_start re-pulsed after 2 of 4 samples -> those 2 samples are ignored and the result comes from the following 4 samples only.
REQ-037 SHALL cover: A = 32767 and -32768, shift=0 -> center=-1, upper saturates to 32767, lower saturates to -32768.
REQ-038 SHALL cover: SYS_aresetn asserted mid-ACQUIRE -> all outputs take REQ-029 values asynchronously, and a new FC_start then calibrates correctly.
